// File: rtl/demux_1_4_router_pkg.sv
// rtl/demux_1_4_router_pkg.sv - shared constants and types for the 1:4 write-side router
package demux_1_4_router_pkg;

    localparam int SEL_W      = 2;
    localparam int N_OUT      = 4;
    localparam int FIFO_DEPTH = 2;

    localparam int CH0 = 0;
    localparam int CH1 = 1;
    localparam int CH2 = 2;
    localparam int CH3 = 3;

    typedef logic [SEL_W-1:0] sel_t;
    typedef logic [N_OUT-1:0] ch_mask_t;

    // One-hot decode of a channel select, used to steer the push strobe
    function automatic ch_mask_t sel_onehot(input sel_t sel);
        ch_mask_t m;
        m      = '0;
        m[sel] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/demux_1_4_router_if.sv
// rtl/demux_1_4_router_if.sv - source stream and four destination channels of the router
interface demux_1_4_router_if #(
    parameter int W = 32
);
    logic [W-1:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data0;
    logic [W-1:0] out_data1;
    logic [W-1:0] out_data2;
    logic [W-1:0] out_data3;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic         busy;

    // Producer/consumer side: drives the source stream and the consumer readies
    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data0, out_data1, out_data2, out_data3, out_valid, busy
    );

    // Router side
    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data0, out_data1, out_data2, out_data3, out_valid, busy
    );
endinterface

// File: rtl/demux_out_fifo2.sv
// rtl/demux_out_fifo2.sv - two-entry registered FIFO feeding one router output channel
module demux_out_fifo2
    import demux_1_4_router_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         valid,
    output logic         full
);

    logic [W-1:0] r_mem [FIFO_DEPTH];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;
    // Last head handed to the consumer; shown while empty so out_data does not jump
    logic [W-1:0] r_last;

    logic w_push;
    logic w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & valid;

    // Storage, pointers and occupancy; reset discards every entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign valid     = (r_count != 2'd0);
    assign full      = (r_count == 2'(FIFO_DEPTH));
    assign head_data = valid ? r_mem[r_rd_ptr] : r_last;

endmodule

// File: rtl/demux_1_4_router.sv
// rtl/demux_1_4_router.sv - routes one source stream to one of four buffered channels
module demux_1_4_router
    import demux_1_4_router_pkg::*;
#(
    parameter int W = 32
) (
    input  logic              clk,
    input  logic              rst,
    demux_1_4_router_if.slave bus
);

    logic [N_OUT-1:0] w_full;
    logic [N_OUT-1:0] w_valid;
    logic [N_OUT-1:0] w_push;
    logic [N_OUT-1:0] w_pop;
    logic [W-1:0]     w_head [N_OUT];
    logic             w_in_ready;

    // Depends only on registered fullness and the select, never on out_ready
    assign w_in_ready = ~w_full[bus.in_sel];
    assign bus.in_ready = w_in_ready;

    // Steer the accepted beat to exactly one channel
    always_comb begin
        w_push = '0;
        if (bus.in_valid && w_in_ready) begin
            w_push = sel_onehot(bus.in_sel);
        end
    end

    assign w_pop = w_valid & bus.out_ready;

    for (genvar g = 0; g < N_OUT; g++) begin : g_ch
        demux_out_fifo2 #(.W(W)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (w_push[g]),
            .push_data (bus.in_data),
            .pop       (w_pop[g]),
            .head_data (w_head[g]),
            .valid     (w_valid[g]),
            .full      (w_full[g])
        );
    end

    assign bus.out_data0 = w_head[CH0];
    assign bus.out_data1 = w_head[CH1];
    assign bus.out_data2 = w_head[CH2];
    assign bus.out_data3 = w_head[CH3];
    assign bus.out_valid = w_valid;
    assign bus.busy      = |w_valid;

endmodule

// File: tb/tb_demux_1_4_router.sv
// tb/tb_demux_1_4_router.sv - scoreboard bench for the 1:4 router
module tb_demux_1_4_router;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    bit   mon_en;

    logic [31:0] q [4][$];

    demux_1_4_router_if #(.W(32)) ifc ();

    demux_1_4_router #(.W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] head_of(input int ch);
        case (ch)
            0:       return ifc.out_data0;
            1:       return ifc.out_data1;
            2:       return ifc.out_data2;
            default: return ifc.out_data3;
        endcase
    endfunction

    // Monitor: occupancy, in_ready and popped data checked against the scoreboard
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            logic [3:0] exp_v;
            for (int i = 0; i < 4; i++) exp_v[i] = (q[i].size() != 0);
            chk("out_valid", {28'd0, ifc.out_valid}, {28'd0, exp_v});
            chk("busy", {31'd0, ifc.busy}, {31'd0, |exp_v});
            if (ifc.in_valid)
                chk("in_ready", {31'd0, ifc.in_ready}, {31'd0, q[ifc.in_sel].size() != 2});
            for (int i = 0; i < 4; i++) begin
                if (ifc.out_valid[i] && ifc.out_ready[i]) begin
                    if (q[i].size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL pop_ch%0d: got %h expected nothing", i, head_of(i));
                    end else begin
                        chk($sformatf("data_ch%0d", i), head_of(i), q[i].pop_front());
                    end
                end
            end
        end
    end

    task automatic drive(input logic [1:0] s, input logic [31:0] d, output logic acc);
        ifc.in_valid = 1'b1;
        ifc.in_sel   = s;
        ifc.in_data  = d;
        @(negedge clk);
        acc = ifc.in_ready;
        @(posedge clk);
        if (acc) q[s].push_back(d);
        #1;
        ifc.in_valid = 1'b0;
    endtask

    task automatic send(input logic [1:0] s, input logic [31:0] d);
        logic acc;
        int   tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            drive(s, d, acc);
            tries++;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got no accept expected accept for %h", d);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) q[i].delete();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic acc;
        n_cmp = 0;
        n_err = 0;
        mon_en = 1'b0;
        rst = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_sel    = 2'd0;
        ifc.in_data   = '0;
        ifc.out_ready = 4'h0;
        idle(2);
        do_reset();
        mon_en = 1'b1;

        // 1. reset after activity
        send(2'd0, 32'h0000_0077);
        send(2'd2, 32'h0000_0078);
        do_reset();
        @(negedge clk);
        chk("rst_valid", {28'd0, ifc.out_valid}, 32'h0);
        chk("rst_d0", ifc.out_data0, 32'h0);
        chk("rst_d2", ifc.out_data2, 32'h0);
        chk("rst_ready", {31'd0, ifc.in_ready}, 32'h1);
        chk("rst_busy", {31'd0, ifc.busy}, 32'h0);
        @(posedge clk);
        #1;

        // 2. route one beat to each channel
        send(2'd0, 32'h0000_00A0);
        send(2'd1, 32'h0000_00B1);
        send(2'd2, 32'h0000_00C2);
        send(2'd3, 32'h0000_00D3);
        @(negedge clk);
        chk("route_valid", {28'd0, ifc.out_valid}, 32'hF);
        chk("route_d0", ifc.out_data0, 32'hA0);
        chk("route_d1", ifc.out_data1, 32'hB1);
        chk("route_d2", ifc.out_data2, 32'hC2);
        chk("route_d3", ifc.out_data3, 32'hD3);
        @(posedge clk);
        #1;
        ifc.out_ready = 4'hF;
        idle(1);
        ifc.out_ready = 4'h0;
        @(negedge clk);
        chk("hold_d1", ifc.out_data1, 32'hB1);
        @(posedge clk);
        #1;

        // 3. backpressure on ch2 only
        send(2'd2, 32'h11);
        send(2'd2, 32'h22);
        drive(2'd2, 32'h33, acc);
        chk("ch2_stall", {31'd0, acc}, 32'h0);
        drive(2'd0, 32'h44, acc);
        chk("ch0_accept", {31'd0, acc}, 32'h1);
        ifc.out_ready = 4'b0100;
        send(2'd2, 32'h33);
        idle(3);
        ifc.out_ready = 4'hF;
        idle(2);
        ifc.out_ready = 4'h0;

        // 4. push and pop together at count=1 on ch1
        send(2'd1, 32'h55);
        ifc.out_ready = 4'b0010;
        drive(2'd1, 32'h66, acc);
        chk("pp_accept", {31'd0, acc}, 32'h1);
        ifc.out_ready = 4'h0;
        @(negedge clk);
        chk("pp_head", ifc.out_data1, 32'h66);
        chk("pp_valid", {31'd0, ifc.out_valid[1]}, 32'h1);
        @(posedge clk);
        #1;
        ifc.out_ready = 4'b0010;
        idle(1);
        ifc.out_ready = 4'h0;

        // 5. streaming on ch3
        ifc.out_ready = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            drive(2'd3, 32'h300 + k, acc);
            chk("stream_accept", {31'd0, acc}, 32'h1);
        end
        idle(2);
        ifc.out_ready = 4'h0;

        // 6. reset with entries stored
        send(2'd0, 32'h61);
        send(2'd0, 32'h62);
        send(2'd3, 32'h63);
        do_reset();
        send(2'd3, 32'h64);
        @(negedge clk);
        chk("post_rst_valid", {28'd0, ifc.out_valid}, 32'h8);
        chk("post_rst_d3", ifc.out_data3, 32'h64);
        @(posedge clk);
        #1;
        ifc.out_ready = 4'hF;
        idle(2);
        ifc.out_ready = 4'h0;
        idle(1);

        for (int i = 0; i < 4; i++)
            chk($sformatf("drained_ch%0d", i), q[i].size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
